mem_access_stage: RTL and testbench

//  EX/MEM register, data-memory access FSM and MEM/WB register in one block. Sits downstream of the execute stage fed by

---
 rtl/mem_access_stage.sv | 187 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: EX/MEM register, data-memory req/ack FSM, load/store
// formatting and MEM/WB register.
// Optional build macro: MEM_MISALIGN_CHECK_EN. When it is defined, misaligned
// halfword/word accesses are not sent to memory. They retire with
// regWrite_MEMOut=0 and misalign_MEMOut=1.
module mem_access_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  flush,
    input  logic                  valid_EXIn,
    input  logic [XLEN-1:0]       aluResult_EXIn,
    input  logic [XLEN-1:0]       storeData_EXIn,
    input  logic [2:0]            func3_EXIn,
    input  logic                  memWrite_EXIn,
    input  logic                  memRead_EXIn,
    input  logic                  regWrite_EXIn,
    input  logic                  memToRegWrite_EXIn,
    input  logic [REG_ADDR_W-1:0] rd_EXIn,
    output logic                  stall_MEMOut,
    output logic                  dmemReq,
    output logic                  dmemWe,
    output logic [XLEN-1:0]       dmemAddr,
    output logic [XLEN-1:0]       dmemWData,
    output logic [3:0]            dmemByteEn,
    input  logic                  dmemAck,
    input  logic [XLEN-1:0]       dmemRData,
    output logic                  valid_MEMOut,
    output logic                  regWrite_MEMOut,
    output logic                  memToRegWrite_MEMOut,
    output logic [XLEN-1:0]       aluResult_MEMOut,
    output logic [XLEN-1:0]       loadData_MEMOut,
    output logic [REG_ADDR_W-1:0] rd_MEMOut
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic                  misalign_MEMOut
`endif
);

    // REQ means M holds a memory op that is waiting for dmemAck.
    typedef enum logic {IDLE, REQ} state_t;
    state_t state, state_nxt;

    // EX/MEM register contents
    logic                  m_valid, m_we, m_re, m_rw, m_m2r;
    logic [XLEN-1:0]       m_alu, m_sdata;
    logic [2:0]            m_f3;
    logic [REG_ADDR_W-1:0] m_rd;

    logic            ex_mis, m_mis, ex_mem;
    logic [3:0]      be;
    logic [XLEN-1:0] wd, ld_fmt;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic            leaving;

`ifdef MEM_MISALIGN_CHECK_EN
    // Size comes from func3[1:0]. 00 is byte, 01 is halfword, anything else is word.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = a[0];
            default: misaligned = (a != 2'b00);
        endcase
    endfunction
    assign ex_mis = (memRead_EXIn | memWrite_EXIn) & misaligned(func3_EXIn, aluResult_EXIn[1:0]);
    assign m_mis  = (m_re | m_we) & misaligned(m_f3, m_alu[1:0]);
`else
    assign ex_mis = 1'b0;
    assign m_mis  = 1'b0;
`endif

    // This is the op that M captures on the next unstalled edge, if it needs the memory port.
    assign ex_mem       = valid_EXIn & ~flush & (memRead_EXIn | memWrite_EXIn) & ~ex_mis;
    assign stall_MEMOut = (state == REQ) & ~dmemAck;
    // M retires into WB on every edge where it is not stalled.
    assign leaving      = ~stall_MEMOut & m_valid;

    // FSM state register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state. The FSM enters or stays in REQ when a memory op is being
    // captured into M. That lets back-to-back accesses issue with no bubble.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = ex_mem ? REQ : IDLE;
            REQ:     if (dmemAck) state_nxt = ex_mem ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // EX/MEM register. It holds while an access is outstanding. Flush only
    // squashes the op being captured, never one already in M.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m_valid <= 1'b0;
            m_we    <= 1'b0;
            m_re    <= 1'b0;
            m_rw    <= 1'b0;
            m_m2r   <= 1'b0;
            m_alu   <= '0;
            m_sdata <= '0;
            m_f3    <= '0;
            m_rd    <= '0;
        end else if (!stall_MEMOut) begin
            m_valid <= valid_EXIn & ~flush;
            m_we    <= memWrite_EXIn;
            m_re    <= memRead_EXIn;
            m_rw    <= regWrite_EXIn;
            m_m2r   <= memToRegWrite_EXIn;
            m_alu   <= aluResult_EXIn;
            m_sdata <= storeData_EXIn;
            m_f3    <= func3_EXIn;
            m_rd    <= rd_EXIn;
        end
    end

    // Store lane replication and byte enables, plus load lane extraction and extension.
    always_comb begin
        be       = 4'hF;
        wd       = m_sdata;
        byte_sel = dmemRData[{m_alu[1:0], 3'b000} +: 8];
        half_sel = m_alu[1] ? dmemRData[31:16] : dmemRData[15:0];
        case (m_f3[1:0])
            2'b00: begin
                be = 4'b0001 << m_alu[1:0];
                wd = {4{m_sdata[7:0]}};
            end
            2'b01: begin
                be = 4'b0011 << {m_alu[1], 1'b0};
                wd = {2{m_sdata[15:0]}};
            end
            default: ;
        endcase
        case (m_f3)
            3'b000:  ld_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ld_fmt = {{16{half_sel[15]}}, half_sel};
            3'b100:  ld_fmt = {24'h0, byte_sel};
            3'b101:  ld_fmt = {16'h0, half_sel};
            default: ld_fmt = dmemRData;
        endcase
    end

    // The memory port is gated by REQ, so an idle port (or one in reset) drives all zeros.
    assign dmemReq    = (state == REQ);
    assign dmemWe     = dmemReq & m_we;
    assign dmemAddr   = dmemReq ? {m_alu[XLEN-1:2], 2'b00} : '0;
    assign dmemWData  = dmemReq ? wd : '0;
    assign dmemByteEn = dmemReq ? be : 4'h0;

    // MEM/WB register. When nothing retires, valid and regWrite drop and the data fields hold.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            valid_MEMOut         <= 1'b0;
            regWrite_MEMOut      <= 1'b0;
            memToRegWrite_MEMOut <= 1'b0;
            aluResult_MEMOut     <= '0;
            loadData_MEMOut      <= '0;
            rd_MEMOut            <= '0;
        end else if (leaving) begin
            valid_MEMOut         <= 1'b1;
            regWrite_MEMOut      <= m_rw & ~m_mis;
            memToRegWrite_MEMOut <= m_m2r;
            aluResult_MEMOut     <= m_alu;
            rd_MEMOut            <= m_rd;
            if (m_re && !m_mis) loadData_MEMOut <= ld_fmt;
        end else begin
            valid_MEMOut         <= 1'b0;
            regWrite_MEMOut      <= 1'b0;
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    // One-cycle misalign flag that travels with the retiring op.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) misalign_MEMOut <= 1'b0;
        else       misalign_MEMOut <= leaving & m_mis;
    end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage. It uses hand-computed expected values and immediate assertions.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rstN;
    logic        flush, valid_EXIn;
    logic [31:0] aluResult_EXIn, storeData_EXIn;
    logic [2:0]  func3_EXIn;
    logic        memWrite_EXIn, memRead_EXIn, regWrite_EXIn, memToRegWrite_EXIn;
    logic [4:0]  rd_EXIn;
    logic        stall_MEMOut, dmemReq, dmemWe;
    logic [31:0] dmemAddr, dmemWData;
    logic [3:0]  dmemByteEn;
    logic        dmemAck;
    logic [31:0] dmemRData;
    logic        valid_MEMOut, regWrite_MEMOut, memToRegWrite_MEMOut;
    logic [31:0] aluResult_MEMOut, loadData_MEMOut;
    logic [4:0]  rd_MEMOut;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign_MEMOut;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk(clk), .rstN(rstN), .flush(flush), .valid_EXIn(valid_EXIn),
        .aluResult_EXIn(aluResult_EXIn), .storeData_EXIn(storeData_EXIn),
        .func3_EXIn(func3_EXIn), .memWrite_EXIn(memWrite_EXIn), .memRead_EXIn(memRead_EXIn),
        .regWrite_EXIn(regWrite_EXIn), .memToRegWrite_EXIn(memToRegWrite_EXIn),
        .rd_EXIn(rd_EXIn), .stall_MEMOut(stall_MEMOut), .dmemReq(dmemReq), .dmemWe(dmemWe),
        .dmemAddr(dmemAddr), .dmemWData(dmemWData), .dmemByteEn(dmemByteEn),
        .dmemAck(dmemAck), .dmemRData(dmemRData), .valid_MEMOut(valid_MEMOut),
        .regWrite_MEMOut(regWrite_MEMOut), .memToRegWrite_MEMOut(memToRegWrite_MEMOut),
        .aluResult_MEMOut(aluResult_MEMOut), .loadData_MEMOut(loadData_MEMOut),
        .rd_MEMOut(rd_MEMOut)
`ifdef MEM_MISALIGN_CHECK_EN
        , .misalign_MEMOut(misalign_MEMOut)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic [31:0] alu, input logic [31:0] sd, input logic [2:0] f3,
                      input logic we, input logic re, input logic rw, input logic m2r,
                      input logic [4:0] rd);
        valid_EXIn = 1'b1; aluResult_EXIn = alu; storeData_EXIn = sd; func3_EXIn = f3;
        memWrite_EXIn = we; memRead_EXIn = re; regWrite_EXIn = rw;
        memToRegWrite_EXIn = m2r; rd_EXIn = rd;
    endtask

    task automatic ex_idle();
        valid_EXIn = 1'b0; memWrite_EXIn = 1'b0; memRead_EXIn = 1'b0;
        regWrite_EXIn = 1'b0; memToRegWrite_EXIn = 1'b0;
    endtask

    // This is a load acked in its first REQ cycle. It checks the word address and the formatted result.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        ex(addr, 32'h0, f3, 1'b0, 1'b1, 1'b1, 1'b1, 5'd4);
        tick();
        ex_idle();
        check({tag, "_addr"}, dmemAddr, {addr[31:2], 2'b00});
        dmemAck = 1'b1; dmemRData = rdata;
        #1;
        check({tag, "_nostall"}, {31'h0, stall_MEMOut}, 32'h0);
        tick();
        dmemAck = 1'b0;
        check({tag, "_data"}, loadData_MEMOut, exp);
    endtask

    // This is a store. It checks byte enables and lane replication, then acks it.
    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sd, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd);
        ex(addr, sd, f3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        tick();
        ex_idle();
        check({tag, "_be"}, {28'h0, dmemByteEn}, {28'h0, exp_be});
        check({tag, "_wdata"}, dmemWData, exp_wd);
        dmemAck = 1'b1;
        tick();
        dmemAck = 1'b0;
        check({tag, "_retire"}, {31'h0, valid_MEMOut}, 32'h1);
    endtask

    initial begin
        rstN = 1'b0; flush = 1'b0; dmemAck = 1'b0; dmemRData = '0;
        aluResult_EXIn = '0; storeData_EXIn = '0; func3_EXIn = '0; rd_EXIn = '0;
        ex_idle();
        repeat (2) tick();
        check("rst_valid", {31'h0, valid_MEMOut}, 32'h0);
        check("rst_req",   {31'h0, dmemReq}, 32'h0);
        check("rst_alu",   aluResult_MEMOut, 32'h0);
        check("rst_stall", {31'h0, stall_MEMOut}, 32'h0);
        rstN = 1'b1;
        tick();

        // A non-memory op retires one edge after M captures it.
        ex(32'h1234, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5);
        tick();
        ex_idle();
        check("add_noreq", {31'h0, dmemReq}, 32'h0);
        tick();
        check("add_valid", {31'h0, valid_MEMOut}, 32'h1);
        check("add_alu",   aluResult_MEMOut, 32'h1234);
        check("add_rd",    {27'h0, rd_MEMOut}, 32'd5);
        check("add_rw",    {31'h0, regWrite_MEMOut}, 32'h1);
        tick();
        check("add_drop",  {31'h0, valid_MEMOut}, 32'h0);
        check("add_hold",  aluResult_MEMOut, 32'h1234);

        // LB at 0x103 stalls three cycles, then the ack in the fourth cycle returns 0x80 in lane 3.
        ex(32'h103, 32'h0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7);
        tick();
        ex_idle();
        for (int i = 0; i < 3; i++) begin
            check("lb_stall", {31'h0, stall_MEMOut}, 32'h1);
            check("lb_req",   {31'h0, dmemReq}, 32'h1);
            tick();
        end
        check("lb_addr", dmemAddr, 32'h100);
        dmemAck = 1'b1; dmemRData = 32'h8012_3456;
        #1;
        check("lb_ackstall", {31'h0, stall_MEMOut}, 32'h0);
        tick();
        dmemAck = 1'b0;
        check("lb_valid", {31'h0, valid_MEMOut}, 32'h1);
        check("lb_data",  loadData_MEMOut, 32'hFFFF_FF80);
        check("lb_rd",    {27'h0, rd_MEMOut}, 32'd7);
        check("lb_idle",  {31'h0, dmemReq}, 32'h0);

        // SH at 0x202 drives the upper lanes and holds its request until the ack.
        ex(32'h202, 32'h0000_ABCD, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        tick();
        ex_idle();
        for (int i = 0; i < 2; i++) begin
            check("sh_be",    {28'h0, dmemByteEn}, 32'hC);
            check("sh_wdata", dmemWData, 32'hABCD_ABCD);
            check("sh_we",    {31'h0, dmemWe}, 32'h1);
            check("sh_addr",  dmemAddr, 32'h200);
            tick();
        end
        dmemAck = 1'b1;
        tick();
        dmemAck = 1'b0;
        check("sh_retire", {31'h0, valid_MEMOut}, 32'h1);
        check("sh_rw",     {31'h0, regWrite_MEMOut}, 32'h0);

        // Other store widths and load extensions
        do_store("sb1", 3'b000, 32'h101, 32'h0000_00E7, 4'b0010, 32'hE7E7_E7E7);
        do_store("sw",  3'b010, 32'h300, 32'hDEAD_BEEF, 4'hF,    32'hDEAD_BEEF);
        do_load("lh",  3'b001, 32'h100, 32'h1234_F00D, 32'hFFFF_F00D);
        do_load("lhu", 3'b101, 32'h102, 32'h8001_0000, 32'h0000_8001);
        do_load("lbu", 3'b100, 32'h101, 32'h0000_9A00, 32'h0000_009A);
        do_load("lw",  3'b010, 32'h308, 32'hCAFE_F00D, 32'hCAFE_F00D);
        do_load("f3x", 3'b111, 32'h30C, 32'h0BAD_CAFE, 32'h0BAD_CAFE);

        // Back-to-back LW: each is acked in its first REQ cycle, and there is no bubble between them.
        ex(32'h300, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1);
        tick();
        ex(32'h304, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 5'd2);
        dmemAck = 1'b1; dmemRData = 32'h1111_1111;
        tick();
        ex_idle();
        dmemRData = 32'h2222_2222;
        check("b2b_v1",   {31'h0, valid_MEMOut}, 32'h1);
        check("b2b_d1",   loadData_MEMOut, 32'h1111_1111);
        check("b2b_rd1",  {27'h0, rd_MEMOut}, 32'd1);
        check("b2b_req2", {31'h0, dmemReq}, 32'h1);
        check("b2b_a2",   dmemAddr, 32'h304);
        tick();
        dmemAck = 1'b0;
        check("b2b_v2",  {31'h0, valid_MEMOut}, 32'h1);
        check("b2b_d2",  loadData_MEMOut, 32'h2222_2222);
        check("b2b_rd2", {27'h0, rd_MEMOut}, 32'd2);
        tick();
        check("b2b_end", {31'h0, valid_MEMOut}, 32'h0);

        // A flush during REQ: the older load completes, and the flushed op never reaches WB.
        ex(32'h400, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3);
        tick();
        ex(32'h9999, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9);
        flush = 1'b1;
        tick();
        check("fl_stall", {31'h0, stall_MEMOut}, 32'h1);
        dmemAck = 1'b1; dmemRData = 32'h5A5A_5A5A;
        tick();
        dmemAck = 1'b0; flush = 1'b0;
        ex_idle();
        check("fl_v",  {31'h0, valid_MEMOut}, 32'h1);
        check("fl_d",  loadData_MEMOut, 32'h5A5A_5A5A);
        check("fl_rd", {27'h0, rd_MEMOut}, 32'd3);
        tick();
        check("fl_gone",   {31'h0, valid_MEMOut}, 32'h0);
        check("fl_rdhold", {27'h0, rd_MEMOut}, 32'd3);
        tick();
        check("fl_gone2",  {31'h0, valid_MEMOut}, 32'h0);

        // Reset in the middle of REQ drops the request at once, and nothing is retried.
        ex(32'h500, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 5'd6);
        tick();
        ex_idle();
        check("mr_req", {31'h0, dmemReq}, 32'h1);
        #2 rstN = 1'b0;
        #1;
        check("mr_dropreq", {31'h0, dmemReq}, 32'h0);
        check("mr_addr",    dmemAddr, 32'h0);
        check("mr_be",      {28'h0, dmemByteEn}, 32'h0);
        check("mr_load",    loadData_MEMOut, 32'h0);
        check("mr_rd",      {27'h0, rd_MEMOut}, 32'h0);
        #1 rstN = 1'b1;
        tick();
        check("mr_noretry", {31'h0, dmemReq}, 32'h0);
        check("mr_novalid", {31'h0, valid_MEMOut}, 32'h0);

`ifdef MEM_MISALIGN_CHECK_EN
        // A misaligned LW issues no request and retires flagged, with regWrite off.
        ex(32'h2, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8);
        tick();
        ex_idle();
        check("mis_noreq", {31'h0, dmemReq}, 32'h0);
        tick();
        check("mis_flag",  {31'h0, misalign_MEMOut}, 32'h1);
        check("mis_valid", {31'h0, valid_MEMOut}, 32'h1);
        check("mis_rw",    {31'h0, regWrite_MEMOut}, 32'h0);
        tick();
        check("mis_clear", {31'h0, misalign_MEMOut}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
